// File: rtl/pixel_pkg.sv
// pixel_pkg
//   Shared types and defaults for the RGB-to-gray video pipeline.
//   - mode_t  : per-beat operating mode (pass, gray, threshold, inverted gray)
//   - CH_W_DEF, COEF_W_DEF : default channel and coefficient widths
//   - LUMA_R/G/B : default luma weights (sum to 255, i.e. ~1.0 in Q0.8)
//   - pixel_t : packed {R,G,B} pixel at the default channel width
package pixel_pkg;

  localparam int CH_W_DEF   = 8;
  localparam int COEF_W_DEF = 8;

  localparam int LUMA_R = 76;
  localparam int LUMA_G = 151;
  localparam int LUMA_B = 28;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_INVERT = 2'd3
  } mode_t;

  typedef logic [3*CH_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/rgb_gray_pipe_if.sv
// rgb_gray_pipe_if
//   Stream bundle around rgb_gray_pipe: the input valid/ready beat with its
//   per-beat controls (mode, thr) and sideband flags, and the output beat.
//   Modports:
//   - master : the environment (pixel source + sink), drives in_* / mode /
//              thr / out_ready and observes in_ready and out_*
//   - slave  : the pipeline itself
//   Parameter CH_W : bits per colour channel (pixel is 3*CH_W bits).
interface rgb_gray_pipe_if
  import pixel_pkg::*;
#(
  parameter int CH_W = CH_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [3*CH_W-1:0] in_pixel;
  logic              in_sof;
  logic              in_eol;
  logic [1:0]        mode;
  logic [CH_W-1:0]   thr;

  logic              out_valid;
  logic              out_ready;
  logic [3*CH_W-1:0] out_pixel;
  logic              out_sof;
  logic              out_eol;

  modport master (
    output in_valid, in_pixel, in_sof, in_eol, mode, thr, out_ready,
    input  in_ready, out_valid, out_pixel, out_sof, out_eol
  );

  modport slave (
    input  in_valid, in_pixel, in_sof, in_eol, mode, thr, out_ready,
    output in_ready, out_valid, out_pixel, out_sof, out_eol
  );

endinterface

// File: rtl/gray_luma_mac.sv
// gray_luma_mac
//   Luma datapath split across the pipeline register boundary.
//   Front half (before S1): per-channel products R*R_COEF, G*G_COEF, B*B_COEF.
//   Back half (after S1):   sum of the registered products, right shift by
//   COEF_W, saturate to 2^CH_W-1.
//   Purely combinational; the caller owns the registers in between.
//   Ports:
//   - pixel              : {R,G,B} input pixel feeding the multipliers
//   - prod_r/g/b         : products to be registered in S1
//   - s1_prod_r/g/b      : products as held in S1
//   - y                  : saturated luma
//   Build option RGB_GRAY_ROUND_EN: add half an LSB before the shift
//   (round-half-up); otherwise the shift truncates.
module gray_luma_mac
  import pixel_pkg::*;
#(
  parameter int CH_W   = CH_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int R_COEF = LUMA_R,
  parameter int G_COEF = LUMA_G,
  parameter int B_COEF = LUMA_B
) (
  input  logic [3*CH_W-1:0]      pixel,
  output logic [CH_W+COEF_W-1:0] prod_r,
  output logic [CH_W+COEF_W-1:0] prod_g,
  output logic [CH_W+COEF_W-1:0] prod_b,
  input  logic [CH_W+COEF_W-1:0] s1_prod_r,
  input  logic [CH_W+COEF_W-1:0] s1_prod_g,
  input  logic [CH_W+COEF_W-1:0] s1_prod_b,
  output logic [CH_W-1:0]        y
);

  localparam int PROD_W = CH_W + COEF_W;
  // Two extra bits hold the carry of a three-term sum (plus rounding).
  localparam int SUM_W  = PROD_W + 2;

  localparam logic [COEF_W-1:0] COEF_R = COEF_W'(R_COEF);
  localparam logic [COEF_W-1:0] COEF_G = COEF_W'(G_COEF);
  localparam logic [COEF_W-1:0] COEF_B = COEF_W'(B_COEF);

`ifdef RGB_GRAY_ROUND_EN
  localparam logic [SUM_W-1:0] ROUND_HALF = SUM_W'(1) << (COEF_W - 1);
`endif

  logic [CH_W-1:0]  ch_r;
  logic [CH_W-1:0]  ch_g;
  logic [CH_W-1:0]  ch_b;
  logic [SUM_W-1:0] sum;
  logic [CH_W+1:0]  y_wide;
  logic             unused_frac;

  assign ch_r = pixel[3*CH_W-1 -: CH_W];
  assign ch_g = pixel[2*CH_W-1 -: CH_W];
  assign ch_b = pixel[CH_W-1:0];

  assign prod_r = PROD_W'(ch_r) * PROD_W'(COEF_R);
  assign prod_g = PROD_W'(ch_g) * PROD_W'(COEF_G);
  assign prod_b = PROD_W'(ch_b) * PROD_W'(COEF_B);

  always_comb begin
    sum = SUM_W'(s1_prod_r) + SUM_W'(s1_prod_g) + SUM_W'(s1_prod_b);
`ifdef RGB_GRAY_ROUND_EN
    sum = sum + ROUND_HALF;
`endif
  end

  // Fractional bits below the shift point are discarded by design.
  assign y_wide      = sum[SUM_W-1:COEF_W];
  assign unused_frac = ^sum[COEF_W-1:0];

  // Coefficients whose total exceeds 2^COEF_W can push the result past the
  // channel range; clamp instead of wrapping.
  assign y = (|y_wide[CH_W+1:CH_W]) ? {CH_W{1'b1}} : y_wide[CH_W-1:0];

endmodule

// File: rtl/rgb_gray_pipe.sv
// rgb_gray_pipe
//   Two-stage pipelined RGB-to-gray converter on a valid/ready stream.
//   Modes (per accepted beat): PASS, GRAY {y,y,y}, THRESH (all-ones when
//   y >= thr), INVERT {~y,~y,~y}. SOF/EOL ride along with each pixel.
//   Latency 2 cycles, throughput 1 beat/clk, at most 2 beats held.
//   Ports:
//   - clk   : rising-edge clock
//   - rst_n : synchronous active-low reset, discards in-flight beats
//   - bus   : rgb_gray_pipe_if.slave (in_* / mode / thr / in_ready,
//             out_* / out_valid / out_ready)
//   Build option RGB_GRAY_ROUND_EN (applied inside gray_luma_mac):
//   round-half-up luma instead of truncation; timing and ports unchanged.
module rgb_gray_pipe
  import pixel_pkg::*;
#(
  parameter int CH_W   = CH_W_DEF,
  parameter int COEF_W = COEF_W_DEF,
  parameter int R_COEF = LUMA_R,
  parameter int G_COEF = LUMA_G,
  parameter int B_COEF = LUMA_B
) (
  input  logic           clk,
  input  logic           rst_n,
  rgb_gray_pipe_if.slave bus
);

  localparam int PIX_W  = 3 * CH_W;
  localparam int PROD_W = CH_W + COEF_W;

  logic              en1;
  logic              en2;
  logic              v1;
  logic              v2;

  logic [PIX_W-1:0]  s1_pixel;
  mode_t             s1_mode;
  logic [CH_W-1:0]   s1_thr;
  logic              s1_sof;
  logic              s1_eol;
  logic [PROD_W-1:0] s1_prod_r;
  logic [PROD_W-1:0] s1_prod_g;
  logic [PROD_W-1:0] s1_prod_b;

  logic [PROD_W-1:0] prod_r;
  logic [PROD_W-1:0] prod_g;
  logic [PROD_W-1:0] prod_b;
  logic [CH_W-1:0]   y;
  logic [PIX_W-1:0]  result;

  logic [PIX_W-1:0]  out_pixel_q;
  logic              out_sof_q;
  logic              out_eol_q;

  // A stage may load when it is empty or its content moves on this cycle;
  // in_ready therefore depends only on state and out_ready.
  assign en2 = !v2 || bus.out_ready;
  assign en1 = !v1 || en2;

  assign bus.in_ready  = en1;
  assign bus.out_valid = v2;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eol   = out_eol_q;

  gray_luma_mac #(
    .CH_W   (CH_W),
    .COEF_W (COEF_W),
    .R_COEF (R_COEF),
    .G_COEF (G_COEF),
    .B_COEF (B_COEF)
  ) u_mac (
    .pixel     (bus.in_pixel),
    .prod_r    (prod_r),
    .prod_g    (prod_g),
    .prod_b    (prod_b),
    .s1_prod_r (s1_prod_r),
    .s1_prod_g (s1_prod_g),
    .s1_prod_b (s1_prod_b),
    .y         (y)
  );

  always_comb begin
    result = s1_pixel;
    case (s1_mode)
      MODE_PASS:   result = s1_pixel;
      MODE_GRAY:   result = {3{y}};
      MODE_THRESH: result = (y >= s1_thr) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      MODE_INVERT: result = {3{~y}};
    endcase
  end

  // Data registers only load on real beats so the output stays quiet
  // between transfers; valids always follow their enables.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      s1_pixel    <= '0;
      s1_mode     <= MODE_PASS;
      s1_thr      <= '0;
      s1_sof      <= 1'b0;
      s1_eol      <= 1'b0;
      s1_prod_r   <= '0;
      s1_prod_g   <= '0;
      s1_prod_b   <= '0;
      out_pixel_q <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          s1_pixel  <= bus.in_pixel;
          s1_mode   <= mode_t'(bus.mode);
          s1_thr    <= bus.thr;
          s1_sof    <= bus.in_sof;
          s1_eol    <= bus.in_eol;
          s1_prod_r <= prod_r;
          s1_prod_g <= prod_g;
          s1_prod_b <= prod_b;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          out_pixel_q <= result;
          out_sof_q   <= s1_sof;
          out_eol_q   <= s1_eol;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_gray_pipe.sv
// tb_rgb_gray_pipe
//   Self-checking bench for rgb_gray_pipe. A scoreboard queue holds the
//   expected output of every accepted beat, computed from the luma rules
//   with plain integer arithmetic; every output transfer is compared with
//   the queue head. Directed steps cover reset, latency, the reference
//   vectors, backpressure and mid-stream reset; a random phase follows.
//   Honours RGB_GRAY_ROUND_EN the same way the design does.
module tb_rgb_gray_pipe;
  import pixel_pkg::*;

  typedef struct {
    logic [23:0] pix;
    logic        sof;
    logic        eol;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;
  logic last_acc;
  beat_t sb_q[$];

`ifdef RGB_GRAY_ROUND_EN
  localparam logic [23:0] EXP_RED_GRAY = 24'h4C4C4C;
`else
  localparam logic [23:0] EXP_RED_GRAY = 24'h4B4B4B;
`endif

  rgb_gray_pipe_if #(.CH_W(8)) bus ();

  rgb_gray_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Luma as a weighted average of the channels, in plain integers.
  function automatic logic [23:0] model(input logic [23:0] p, input logic [1:0] m,
                                        input logic [7:0] t);
    int r, g, b, s, yv;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    s = 76 * r + 151 * g + 28 * b;
`ifdef RGB_GRAY_ROUND_EN
    s = s + 128;
`endif
    yv = s / 256;
    if (yv > 255) yv = 255;
    case (m)
      2'd0:    return p;
      2'd1:    return 24'(yv * 65793);
      2'd2:    return (yv >= int'(t)) ? 24'hFFFFFF : 24'h000000;
      default: return 24'((255 - yv) * 65793);
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [23:0] p, input logic [1:0] m,
                                input logic [7:0] t, input logic s, input logic e);
    bus.in_valid = v;
    bus.in_pixel = p;
    bus.mode     = m;
    bus.thr      = t;
    bus.in_sof   = s;
    bus.in_eol   = e;
  endtask

  // One clock: observe both handshakes mid-cycle, then advance past the edge.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    last_acc = 1'b0;
    if (rst_n && bus.in_valid && bus.in_ready) begin
      b.pix = model(bus.in_pixel, bus.mode, bus.thr);
      b.sof = bus.in_sof;
      b.eol = bus.in_eol;
      sb_q.push_back(b);
      last_acc = 1'b1;
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_beat", 32'd1, 32'd0);
      end else begin
        b = sb_q.pop_front();
        check_output("out_pixel", 32'(bus.out_pixel), 32'(b.pix));
        check_output("out_sof", 32'(bus.out_sof), 32'(b.sof));
        check_output("out_eol", 32'(bus.out_eol), 32'(b.eol));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    tick();
    tick();
    check_output("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Single beat into an empty pipe, checking the exact 2-cycle latency.
  task automatic send_latency(input logic [23:0] p, input logic [1:0] m, input logic [7:0] t,
                              input logic s, input logic e, input logic [23:0] exp_pix);
    bus.out_ready = 1'b1;
    apply_stimulus(1'b1, p, m, t, s, e);
    tick();
    check_output("lat_accept", 32'(last_acc), 32'd1);
    apply_stimulus(1'b0, 24'h0, 2'd0, 8'h0, 1'b0, 1'b0);
    check_output("lat1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check_output("lat2_valid", 32'(bus.out_valid), 32'd1);
    check_output("lat2_pixel", 32'(bus.out_pixel), 32'(exp_pix));
    check_output("lat2_sof", 32'(bus.out_sof), 32'(s));
    check_output("lat2_eol", 32'(bus.out_eol), 32'(e));
    drain();
  endtask

  initial begin
    logic [23:0] vec_pix [6];
    logic [1:0]  vec_mode[6];
    logic [23:0] stall_pix[4];
    int idx;
    int sent;
    logic pending;

    // Reset state
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    apply_stimulus(1'b0, 24'h0, 2'd0, 8'h0, 1'b0, 1'b0);
    tick();
    tick();
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
    check_output("rst_out_sof", 32'(bus.out_sof), 32'd0);
    check_output("rst_out_eol", 32'(bus.out_eol), 32'd0);
    rst_n = 1'b1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Red through GRAY, then PASS with sideband flags
    send_latency(24'hFF0000, MODE_GRAY, 8'h00, 1'b0, 1'b1, EXP_RED_GRAY);
    send_latency(24'h123456, MODE_PASS, 8'h00, 1'b1, 1'b0, 24'h123456);

    // Reference vectors back to back, including the full-scale white pixel
    vec_pix[0] = 24'h808080; vec_mode[0] = MODE_GRAY;
    vec_pix[1] = 24'hFFFFFF; vec_mode[1] = MODE_GRAY;
    vec_pix[2] = 24'h808080; vec_mode[2] = MODE_THRESH;
    vec_pix[3] = 24'hFF0000; vec_mode[3] = MODE_INVERT;
    vec_pix[4] = 24'h000000; vec_mode[4] = MODE_THRESH;
    vec_pix[5] = 24'hFFFFFF; vec_mode[5] = MODE_INVERT;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, vec_pix[i], vec_mode[i], 8'h80, 1'b0, 1'b0);
      tick();
      check_output("vec_accept", 32'(last_acc), 32'd1);
    end
    drain();

    // Backpressure: four beats, sink stalled for 5 cycles
    for (int i = 0; i < 4; i++) stall_pix[i] = 24'($urandom);
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(1'b1, stall_pix[idx], 2'(idx), 8'h80, 1'(idx == 0), 1'(idx == 3));
      tick();
      if (last_acc) idx++;
      if (c >= 1) begin
        check_output("stall_valid", 32'(bus.out_valid), 32'd1);
        check_output("stall_hold", 32'(bus.out_pixel), 32'(sb_q[0].pix));
      end
    end
    check_output("stall_accepts", 32'(idx), 32'd2);
    check_output("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    apply_stimulus(1'b1, stall_pix[idx], 2'(idx), 8'h80, 1'b0, 1'(idx == 3));
    tick();
    check_output("full_pass_accept", 32'(last_acc), 32'd1);
    if (last_acc) idx++;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      apply_stimulus(1'b1, stall_pix[idx], 2'(idx), 8'h80, 1'b0, 1'(idx == 3));
      tick();
      if (last_acc) idx++;
    end
    check_output("stall_all_sent", 32'(idx), 32'd4);
    drain();

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      apply_stimulus(1'b1, 24'($urandom), MODE_GRAY, 8'h00, 1'b1, 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 24'h0, 2'd0, 8'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    sb_q.delete();
    rst_n = 1'b1;
    check_output("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("midrst_out_pixel", 32'(bus.out_pixel), 32'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_output("midrst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Random traffic with random sink stalls
    sent = 0;
    pending = 1'b0;
    for (int c = 0; c < 600 && sent < 60; c++) begin
      if (!pending && $urandom_range(3) != 0) begin
        apply_stimulus(1'b1, 24'($urandom), 2'($urandom_range(3)), 8'($urandom_range(255)),
                       1'($urandom_range(1)), 1'($urandom_range(1)));
        pending = 1'b1;
      end
      bus.out_ready = ($urandom_range(3) != 0);
      tick();
      if (last_acc) begin
        pending = 1'b0;
        sent++;
        bus.in_valid = 1'b0;
      end
    end
    check_output("rand_sent", 32'(sent), 32'd60);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
